// File: rtl/openhw_fpu_pkg.sv
// Shared divsqrt definitions.
//  divsqrt_st_t        : sign-tracker control states
//  DIVSQRT_CNTW_DFLT   : default iteration counter width
//  DIVSQRT_TAGW_DFLT   : default op tag width
package openhw_fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } divsqrt_st_t;

  localparam int unsigned DIVSQRT_CNTW_DFLT = 6;
  localparam int unsigned DIVSQRT_TAGW_DFLT = 5;

  // Sign of the divsqrt result: sqrt ignores the y sign.
  function automatic logic divsqrt_sign(input logic xs, input logic ys, input logic sqrt);
    return xs ^ (ys & ~sqrt);
  endfunction

endpackage

// File: rtl/openhw_divsqrt_signtrack.sv
// Divsqrt sign/context tracker.
//  Captures operand signs, sqrt flag and tag when an op is issued, counts the
//  iterations of the divsqrt unit and presents the result sign context to the
//  postprocessor with a valid/ready handshake. One operation in flight.
//  Ports:
//   clk, reset                  clock, synchronous active-high reset
//   FlushE                      abort any in-flight op (beats issue/handshake)
//   IssueValid/IssueReady       issue handshake
//   XsE, YsE, SqrtE, SpecialE   operand signs, op kind, early-out flag
//   NumIterE, TagE              iteration count, opaque tag
//   Busy                        op held (BUSY or DONE)
//   ResValid/ResReady           result handshake
//   QsM, SqrtM, TagM            result sign, captured sqrt flag, captured tag
module openhw_divsqrt_signtrack
  import openhw_fpu_pkg::*;
#(
  parameter int unsigned CNTW = DIVSQRT_CNTW_DFLT,
  parameter int unsigned TAGW = DIVSQRT_TAGW_DFLT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            IssueValid,
  output logic            IssueReady,
  input  logic            XsE,
  input  logic            YsE,
  input  logic            SqrtE,
  input  logic            SpecialE,
  input  logic [CNTW-1:0] NumIterE,
  input  logic [TAGW-1:0] TagE,
  output logic            Busy,
  output logic            ResValid,
  input  logic            ResReady,
  output logic            QsM,
  output logic            SqrtM,
  output logic [TAGW-1:0] TagM
);

  divsqrt_st_t     state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            xs_q, xs_d;
  logic            ys_q, ys_d;
  logic            sqrt_q, sqrt_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            accept;

  assign Busy       = (state_q != ST_IDLE);
  assign ResValid   = (state_q == ST_DONE);
  assign IssueReady = ~FlushE & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ResReady));
  assign accept     = IssueValid & IssueReady;

  assign QsM   = divsqrt_sign(xs_q, ys_q, sqrt_q);
  assign SqrtM = sqrt_q;
  assign TagM  = tag_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    sqrt_d  = sqrt_q;
    tag_d   = tag_q;

    if (FlushE) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          // count==0 cannot occur in BUSY; treat it as finished rather than wrap.
          if (count_q > CNTW'(1)) begin
            count_d = count_q - CNTW'(1);
          end else begin
            if (count_q == CNTW'(1)) count_d = '0;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (ResReady) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // accept is only possible in IDLE or in DONE while the result drains,
      // so it overrides the state update above (back-to-back without a bubble).
      if (accept) begin
        xs_d    = XsE;
        ys_d    = YsE;
        sqrt_d  = SqrtE;
        tag_d   = TagE;
        count_d = NumIterE;
        state_d = (SpecialE || (NumIterE == '0)) ? ST_DONE : ST_BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      sqrt_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      sqrt_q  <= sqrt_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_openhw_divsqrt_signtrack.sv
// Testbench for openhw_divsqrt_signtrack: directed scenarios followed by
// randomized traffic, all checked against a completion-time reference model.
module tb_openhw_divsqrt_signtrack;

  localparam int unsigned CNTW = 6;
  localparam int unsigned TAGW = 5;

  logic            clk = 1'b0;
  logic            rst, fl, iv, xs, ys, sq, sp, rr;
  logic [CNTW-1:0] n;
  logic [TAGW-1:0] tg;
  logic            IssueReady, Busy, ResValid, QsM, SqrtM;
  logic [TAGW-1:0] TagM;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: an op in flight completes at a known edge index.
  int unsigned     cyc = 0;
  bit              m_inflight = 0;
  int unsigned     m_done = 0;
  bit              m_qs, m_sqrt;
  logic [TAGW-1:0] m_tag;

  always #5 clk = ~clk;

  openhw_divsqrt_signtrack #(.CNTW(CNTW), .TAGW(TAGW)) dut (
    .clk(clk), .reset(rst), .FlushE(fl), .IssueValid(iv), .IssueReady(IssueReady),
    .XsE(xs), .YsE(ys), .SqrtE(sq), .SpecialE(sp), .NumIterE(n), .TagE(tg),
    .Busy(Busy), .ResValid(ResValid), .ResReady(rr),
    .QsM(QsM), .SqrtM(SqrtM), .TagM(TagM)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_valid();
    return m_inflight && (cyc >= m_done);
  endfunction

  // One clock: check IssueReady against current inputs, advance the model,
  // take the edge, then check the registered outputs.
  task automatic tick();
    bit v, rdy;
    #1;
    v   = m_valid();
    rdy = !fl && (!m_inflight || (v && rr));
    check_eq("IssueReady", {31'b0, IssueReady}, {31'b0, rdy});
    if (rst || fl) begin
      m_inflight = 0;
    end else if (iv && rdy) begin
      m_inflight = 1;
      m_done     = cyc + 1 + ((sp || n == 0) ? 0 : int'(n));
      m_qs       = xs ^ (ys & !sq);
      m_sqrt     = sq;
      m_tag      = tg;
    end else if (v && rr) begin
      m_inflight = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    v = m_valid();
    check_eq("Busy", {31'b0, Busy}, {31'b0, m_inflight});
    check_eq("ResValid", {31'b0, ResValid}, {31'b0, v});
    if (v) begin
      check_eq("QsM", {31'b0, QsM}, {31'b0, m_qs});
      check_eq("SqrtM", {31'b0, SqrtM}, {31'b0, m_sqrt});
      check_eq("TagM", {27'b0, TagM}, {27'b0, m_tag});
    end
  endtask

  task automatic set_op(input bit x, input bit y, input bit s, input bit spc,
                        input int unsigned it, input int unsigned t);
    iv = 1; xs = x; ys = y; sq = s; sp = spc; n = CNTW'(it); tg = TAGW'(t);
  endtask

  task automatic idle_in();
    iv = 0; xs = 0; ys = 0; sq = 0; sp = 0; n = '0; tg = '0; fl = 0; rst = 0;
  endtask

  // Ticks until DUT ResValid, returning the number of ticks taken.
  task automatic wait_valid(input string tag, output int unsigned k);
    k = 0;
    while (!ResValid && k < 100) begin
      tick();
      k++;
    end
    if (!ResValid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int unsigned k;

  initial begin
    idle_in();
    rr  = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    check_eq("rst_QsM", {31'b0, QsM}, 32'd0);
    check_eq("rst_SqrtM", {31'b0, SqrtM}, 32'd0);
    check_eq("rst_TagM", {27'b0, TagM}, 32'd0);

    // Reset held two cycles while BUSY.
    set_op(1, 1, 0, 0, 10, 3); tick(); idle_in();
    tick(); tick(); tick();
    rst = 1; tick(); tick(); rst = 0;
    check_eq("rst_busy_Busy", {31'b0, Busy}, 32'd0);
    check_eq("rst_busy_ResValid", {31'b0, ResValid}, 32'd0);
    #1 check_eq("rst_busy_IssueReady", {31'b0, IssueReady}, 32'd1);
    tick();

    // Divide, 5 iterations, then backpressure and back-to-back sqrt.
    set_op(1, 0, 0, 0, 5, 7); tick(); idle_in();
    wait_valid("div5", k);
    check_eq("div5_latency", k, 32'd5);
    check_eq("div5_QsM", {31'b0, QsM}, 32'd1);
    check_eq("div5_TagM", {27'b0, TagM}, 32'd7);
    for (int unsigned i = 0; i < 4; i++) tick();
    rr = 1; set_op(0, 1, 1, 0, 3, 9); tick(); idle_in();
    check_eq("b2b_ResValid_drop", {31'b0, ResValid}, 32'd0);
    rr = 0;
    wait_valid("sqrt3", k);
    check_eq("sqrt3_QsM", {31'b0, QsM}, 32'd0);
    rr = 1; tick();

    // Special early-out ignores a large iteration count.
    set_op(1, 1, 0, 1, 20, 4); tick(); idle_in();
    check_eq("special_ResValid", {31'b0, ResValid}, 32'd1);
    check_eq("special_QsM", {31'b0, QsM}, 32'd0);
    tick();

    // Flush in BUSY with count 3.
    set_op(0, 1, 0, 0, 6, 11); tick(); idle_in();
    tick(); tick(); tick();
    fl = 1; tick(); fl = 0;
    check_eq("flush_busy_Busy", {31'b0, Busy}, 32'd0);

    // Flush in DONE with ResReady high and a competing issue.
    set_op(1, 0, 0, 0, 0, 2); tick();
    check_eq("n0_ResValid", {31'b0, ResValid}, 32'd1);
    fl = 1; tick(); idle_in();
    check_eq("flush_done_Busy", {31'b0, Busy}, 32'd0);
    tick();

    // Maximum iteration count does not wrap.
    set_op(0, 0, 1, 0, 63, 31); tick(); idle_in();
    wait_valid("n63", k);
    check_eq("n63_latency", k, 32'd63);
    tick();

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      iv  = ($urandom_range(0, 99) < 60);
      xs  = $urandom_range(0, 1);
      ys  = $urandom_range(0, 1);
      sq  = $urandom_range(0, 1);
      sp  = ($urandom_range(0, 99) < 10);
      n   = ($urandom_range(0, 99) < 3) ? CNTW'(63) : CNTW'($urandom_range(0, 8));
      tg  = TAGW'($urandom);
      rr  = ($urandom_range(0, 99) < 70);
      fl  = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) < 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
